// File: rtl/bus_timer.sv
// Memory-mapped down-counting timer (CTRL/PRESET/COUNT) raising IRQ when the count expires.
// Stores take effect at the clock edge; loads are combinational from Addr.
module bus_timer #(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] PRESET_RST = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Sel,
  input  logic [1:0]       Addr,
  input  logic             WE,
  input  logic [WIDTH-1:0] WD,
  output logic [WIDTH-1:0] RD,
  output logic             IRQ
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CNT, S_INT} state_t;

  state_t           state, state_nxt;
  logic [3:0]       ctrl;
  logic [WIDTH-1:0] preset;
  logic [WIDTH-1:0] count;
  logic             irq_flag;
  logic             ctrl_wr, preset_wr, en_eff, auto_reload, expire;

  assign ctrl_wr     = Sel & WE & (Addr == 2'd0);
  assign preset_wr   = Sel & WE & (Addr == 2'd1);
  // A CTRL store landing during CNT is seen at the same edge, so EN=0 freezes COUNT at once.
  assign en_eff      = ctrl_wr ? WD[0] : ctrl[0];
  assign auto_reload = (ctrl[2:1] == 2'b01);
  // COUNT<=1 covers PRESET=0, which therefore never wraps to all-ones.
  assign expire      = (state == S_CNT) && en_eff && (count <= WIDTH'(1));

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (ctrl[0]) state_nxt = S_LOAD;
      S_LOAD:  state_nxt = S_CNT;
      S_CNT: begin
        if (!en_eff)     state_nxt = S_IDLE;
        else if (expire) state_nxt = S_INT;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      ctrl     <= '0;
      preset   <= PRESET_RST;
      count    <= '0;
      irq_flag <= 1'b0;
    end else begin
      state <= state_nxt;

      if (ctrl_wr)
        ctrl <= WD[3:0];
      else if (state == S_INT && !auto_reload)
        ctrl[0] <= 1'b0;

      if (preset_wr)
        preset <= WD;

      if (state == S_LOAD)
        count <= preset;
      else if (state == S_CNT && en_eff)
        count <= expire ? '0 : count - WIDTH'(1);

      // Flag is raised on the edge entering INT; a CTRL store always wins.
      if (ctrl_wr)
        irq_flag <= 1'b0;
      else if (expire)
        irq_flag <= 1'b1;
      else if (state == S_INT && auto_reload)
        irq_flag <= 1'b0;
    end
  end

  always_comb begin
    RD = '0;
    case (Addr)
      2'd0:    RD = {{(WIDTH-4){1'b0}}, ctrl};
      2'd1:    RD = preset;
      2'd2:    RD = count;
      default: RD = '0;
    endcase
  end

  assign IRQ = irq_flag & ctrl[3];

endmodule

// File: tb/tb_bus_timer.sv
// Directed and random checks of bus_timer against a timeline-based reference model.
module tb_bus_timer;
  localparam int             W    = 32;
  localparam logic [W-1:0]   PRST = '0;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         Sel = 1'b0;
  logic         WE = 1'b0;
  logic [1:0]   Addr = 2'd0;
  logic [W-1:0] WD = '0;
  logic [W-1:0] RD;
  logic         IRQ;

  bus_timer #(.WIDTH(W), .PRESET_RST(PRST)) dut (
    .clk(clk), .reset(reset), .Sel(Sel), .Addr(Addr), .WE(WE), .WD(WD), .RD(RD), .IRQ(IRQ)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: registers plus absolute edge numbers of the next load and the expiry.
  logic [3:0]   m_ctrl;
  logic [W-1:0] m_preset, m_count, m_n;
  logic         m_flag;
  int           m_load = -1;
  int           m_exp  = -1;
  int           ecount = 0;

  function automatic logic [W-1:0] m_rd(input logic [1:0] a);
    case (a)
      2'd0:    return {28'h0, m_ctrl};
      2'd1:    return m_preset;
      2'd2:    return m_count;
      default: return '0;
    endcase
  endfunction

  task automatic model_reset();
    m_ctrl = '0; m_preset = PRST; m_count = '0; m_n = '0; m_flag = 1'b0;
    m_load = -1; m_exp = -1;
  endtask

  task automatic model_edge(input logic s, input logic w, input logic [1:0] a, input logic [W-1:0] d);
    logic         wr_ctrl, wr_pre, en_eff;
    logic [3:0]   c_old;
    logic [W-1:0] p_old;
    int           e;
    int           el;
    e       = ecount + 1;
    c_old   = m_ctrl;
    p_old   = m_preset;
    wr_ctrl = s && w && (a == 2'd0);
    wr_pre  = s && w && (a == 2'd1);
    en_eff  = wr_ctrl ? d[0] : c_old[0];
    if (wr_ctrl) begin m_ctrl = d[3:0]; m_flag = 1'b0; end
    if (wr_pre) m_preset = d;
    if (m_exp >= 0 && e == m_exp + 1) begin
      if (c_old[2:1] == 2'b01) m_flag = 1'b0;
      else if (!wr_ctrl)       m_ctrl[0] = 1'b0;
      m_load = -1; m_exp = -1;
    end else if (m_load < 0) begin
      if (c_old[0]) m_load = e + 1;
    end else if (m_exp < 0) begin
      m_n = p_old; m_count = p_old;
      m_exp = e + ((p_old == 0) ? 1 : int'(p_old));
    end else if (!en_eff) begin
      m_load = -1; m_exp = -1;
    end else begin
      el = e - m_load;
      m_count = (el >= int'(m_n)) ? '0 : m_n - W'(el);
      if (e == m_exp && !wr_ctrl) m_flag = 1'b1;
    end
    ecount = e;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: drive, check pre-edge outputs, clock once, advance model.
  task automatic cyc(input logic s, input logic w, input logic [1:0] a, input logic [W-1:0] d,
                     input string tag);
    Sel = s; WE = w; Addr = a; WD = d;
    #1;
    chk({tag, "_rd"}, RD, m_rd(a));
    chk({tag, "_irq"}, W'(IRQ), W'(m_flag & m_ctrl[3]));
    @(posedge clk);
    model_edge(s, w, a, d);
    @(negedge clk);
  endtask

  initial begin
    int e0;
    int rise;
    int nirq;
    logic [W-1:0] frozen;
    int rises[$];
    logic [1:0] ra;
    logic [W-1:0] rd_val;

    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // 1: reset values
    Addr = 2'd0; #1 chk("t1_ctrl", RD, '0);
    Addr = 2'd1; #1 chk("t1_preset", RD, PRST);
    Addr = 2'd2; #1 chk("t1_count", RD, '0);
    Addr = 2'd3; #1 chk("t1_rsvd", RD, '0);
    chk("t1_irq", W'(IRQ), '0);
    @(negedge clk);

    // 2: one-shot, PRESET=5
    cyc(1, 1, 2'd1, 5, "t2_pre");
    cyc(1, 1, 2'd0, 32'h9, "t2_ctrl");
    e0 = ecount; rise = -1;
    for (int k = 0; k < 20; k++) begin
      if (IRQ === 1'b1 && rise < 0) rise = ecount - e0;
      cyc(1, 0, 2'd2, 0, "t2_run");
    end
    chk("t2_rise", W'(rise), W'(7));
    Addr = 2'd0; #1 chk("t2_ctrl_rd", RD, 32'h8);
    @(negedge clk);
    cyc(1, 1, 2'd0, 0, "t2_clr");
    chk("t2_irq_drop", W'(IRQ), '0);

    // 3: auto-reload, PRESET=3
    cyc(1, 1, 2'd1, 3, "t3_pre");
    cyc(1, 1, 2'd0, 32'hB, "t3_ctrl");
    rises.delete();
    for (int k = 0; k < 30; k++) begin
      if (IRQ === 1'b1) rises.push_back(ecount);
      cyc(1, 0, 2'd2, 0, "t3_run");
    end
    chk("t3_npulse", W'(rises.size() >= 3), W'(1));
    for (int i = 1; i < rises.size(); i++) chk("t3_period", W'(rises[i] - rises[i-1]), W'(6));
    for (int k = 0; k < 20 && !(m_count == 2 && m_exp >= 0 && ecount < m_exp); k++)
      cyc(1, 0, 2'd2, 0, "t3_wait");
    frozen = m_count;
    cyc(1, 1, 2'd0, 32'hA, "t3_stop");
    nirq = 0;
    for (int k = 0; k < 12; k++) begin
      if (IRQ === 1'b1) nirq++;
      cyc(1, 0, 2'd2, 0, "t3_frozen");
    end
    chk("t3_no_pulse", W'(nirq), '0);
    Addr = 2'd2; #1 chk("t3_count_frozen", RD, frozen);
    @(negedge clk);

    // 4: PRESET=0 treated as 1
    cyc(1, 1, 2'd1, 0, "t4_pre");
    cyc(1, 1, 2'd0, 32'h9, "t4_ctrl");
    e0 = ecount; rise = -1;
    for (int k = 0; k < 10; k++) begin
      if (IRQ === 1'b1 && rise < 0) rise = ecount - e0;
      cyc(1, 0, 2'd2, 0, "t4_run");
    end
    chk("t4_rise", W'(rise), W'(3));

    // 5: IM=0 -> no IRQ, EN still clears
    cyc(1, 1, 2'd0, 32'h1, "t5_ctrl");
    nirq = 0;
    for (int k = 0; k < 10; k++) begin
      if (IRQ === 1'b1) nirq++;
      cyc(1, 0, 2'd2, 0, "t5_run");
    end
    chk("t5_irq_never", W'(nirq), '0);
    Addr = 2'd0; #1 chk("t5_en_cleared", RD, '0);
    @(negedge clk);

    // 6: async reset mid-count
    cyc(1, 1, 2'd1, 100, "t6_pre");
    cyc(1, 1, 2'd0, 32'h9, "t6_ctrl");
    for (int k = 0; k < 200 && m_count != 50; k++) cyc(1, 0, 2'd2, 0, "t6_run");
    chk("t6_at50", RD, W'(50));
    Sel = 1'b0; WE = 1'b0;
    #2 reset = 1'b0;
    Addr = 2'd0; #1 chk("t6_ctrl", RD, '0);
    Addr = 2'd1; #1 chk("t6_preset", RD, PRST);
    Addr = 2'd2; #1 chk("t6_count", RD, '0);
    chk("t6_irq", W'(IRQ), '0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;

    // unselected stores change nothing
    for (int k = 0; k < 4; k++) cyc(0, 1, 2'(k), $urandom, "t6_nosel");

    // random traffic against the model
    for (int k = 0; k < 400; k++) begin
      ra = 2'($urandom_range(0, 3));
      rd_val = (ra == 2'd1) ? W'($urandom_range(0, 8)) :
               (ra == 2'd0) ? W'($urandom_range(0, 15)) : W'($urandom);
      cyc(1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0), ra, rd_val, "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
